// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: barrier write/flush sequencing for load-use
// bubbles, EX-resolved branch squashes and multi-cycle data-memory freezes,
// with a memory-wait watchdog and saturating performance counters.
module pipeline_hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             idRs1,
    input  logic [4:0]             idRs2,
    input  logic                   idUsesRs1,
    input  logic                   idUsesRs2,
    input  logic                   exMemRead,
    input  logic                   exRegWrite,
    input  logic [4:0]             exRd,
    input  logic                   exBranchTaken,
    input  logic                   memReq,
    input  logic                   memReady,
    output logic                   pcWrite,
    output logic                   ifIdWrite,
    output logic                   ifIdFlush,
    output logic                   idExWrite,
    output logic                   idExFlush,
    output logic                   exMemWrite,
    output logic                   memWbWrite,
    output logic                   memWbFlush,
    output logic                   memTimeout,
    output logic [STALL_CNT_W-1:0] stallCycles,
    output logic [15:0]            flushCount
);

    localparam logic [0:0]  ST_RUN      = 1'b0;
    localparam logic [0:0]  ST_MEM_WAIT = 1'b1;
    localparam logic [15:0] WAIT_LAST   = 16'(MEM_TIMEOUT - 1);

    logic [0:0]             state_q, state_d;
    logic [15:0]            waitCnt_q, waitCnt_d;
    logic                   timeout_q, timeout_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [15:0]            flush_q, flush_d;

    logic loadUse;
    logic waitExpired;
    logic freeze;
    logic branchFlush;

    // Hazard, freeze and watchdog decode from current state and inputs
    always_comb begin
        loadUse = exMemRead && exRegWrite && (exRd != 5'd0) &&
                  ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));
        if (state_q == ST_MEM_WAIT) begin
            waitExpired = !memReady && (waitCnt_q == WAIT_LAST);
            freeze      = !memReady && !waitExpired;
        end else begin
            waitExpired = 1'b0;
            freeze      = memReq && !memReady;
        end
        branchFlush = !rst && !freeze && exBranchTaken;
    end

    // Barrier controls: reset > freeze > branch > load-use > normal
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExWrite  = 1'b1;
        idExFlush  = 1'b0;
        exMemWrite = 1'b1;
        memWbWrite = 1'b1;
        memWbFlush = 1'b0;
        if (rst) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b1;
            idExWrite  = 1'b0;
            idExFlush  = 1'b1;
            exMemWrite = 1'b0;
            memWbWrite = 1'b0;
            memWbFlush = 1'b1;
        end else if (freeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbFlush = 1'b1;
        end else begin
            if (exBranchTaken) begin
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
            end else if (loadUse) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                idExFlush = 1'b1;
            end
            // A forced release must not let the incomplete access reach WB
            if (waitExpired) begin
                memWbFlush = 1'b1;
            end
        end
    end

    // Next-state for FSM, wait counter, sticky flag and counters
    always_comb begin
        state_d   = ST_RUN;
        waitCnt_d = '0;
        if (freeze) begin
            state_d = ST_MEM_WAIT;
            // The RUN cycle that starts the access counts as wait cycle 0,
            // so the first MEM_WAIT cycle already sees a count of 1.
            waitCnt_d = (state_q == ST_MEM_WAIT) ? waitCnt_q + 16'd1 : 16'd1;
        end
        timeout_d = timeout_q || waitExpired;
        stall_d   = (!pcWrite && (stall_q != '1)) ? stall_q + STALL_CNT_W'(1) : stall_q;
        flush_d   = (branchFlush && (flush_q != '1)) ? flush_q + 16'd1 : flush_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            waitCnt_q <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign memTimeout  = timeout_q;
    assign stallCycles = stall_q;
    assign flushCount  = flush_q;

endmodule
